// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS-format instruction decoder with a 2-entry skid buffer
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_class,
    output logic [2:0]       out_op,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic             out_wr_en,
    output logic [4:0]       out_wr_reg,
    output logic [4:0]       out_shamt,
    output logic [XLEN-1:0]  out_imm,
    output logic [CNT_W-1:0] dec_count,
    output logic [CNT_W-1:0] ill_count
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [2:0] C_ARITH = 3'd0, C_LOGIC = 3'd1, C_COMP = 3'd2, C_MEM = 3'd3;
    localparam logic [2:0] C_BRANCH = 3'd4, C_JUMP = 3'd5, C_ILLEGAL = 3'd7;

    localparam logic [1:0] W_NONE = 2'd0, W_RD = 2'd1, W_RT = 2'd2, W_R31 = 2'd3;
    localparam logic [1:0] I_NONE = 2'd0, I_SEXT = 2'd1, I_ZEXT16 = 2'd2, I_ZEXT26 = 2'd3;

    typedef struct packed {
        logic [2:0]      cls;
        logic [2:0]      op;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic            wr_en;
        logic [4:0]      wr_reg;
        logic [4:0]      shamt;
        logic [XLEN-1:0] imm;
    } dec_t;

    logic [5:0] opcode, funct;
    logic [2:0] cls, op;
    logic [1:0] wsel, isel;
    logic       shamt_en;
    dec_t       dec;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        cls      = C_ILLEGAL;
        op       = 3'd0;
        wsel     = W_NONE;
        isel     = I_NONE;
        shamt_en = 1'b0;
        case (opcode)
            6'b000000: begin
                wsel = W_RD;
                case (funct)
                    6'b100000: begin cls = C_ARITH; op = 3'd0; end
                    6'b100010: begin cls = C_ARITH; op = 3'd1; end
                    6'b100001: begin cls = C_ARITH; op = 3'd2; end
                    6'b100011: begin cls = C_ARITH; op = 3'd3; end
                    6'b100100: begin cls = C_LOGIC; op = 3'd0; end
                    6'b100101: begin cls = C_LOGIC; op = 3'd1; end
                    6'b000000: begin cls = C_LOGIC; op = 3'd4; shamt_en = 1'b1; end
                    6'b000010: begin cls = C_LOGIC; op = 3'd5; shamt_en = 1'b1; end
                    6'b101010: begin cls = C_COMP;  op = 3'd0; end
                    6'b001000: begin cls = C_JUMP;  op = 3'd1; wsel = W_NONE; end
                    default:   wsel = W_NONE;
                endcase
            end
            6'b001000: begin cls = C_ARITH;  op = 3'd4; wsel = W_RT; isel = I_SEXT; end
            6'b001001: begin cls = C_ARITH;  op = 3'd6; wsel = W_RT; isel = I_SEXT; end
            6'b001100: begin cls = C_LOGIC;  op = 3'd2; wsel = W_RT; isel = I_ZEXT16; end
            6'b001101: begin cls = C_LOGIC;  op = 3'd3; wsel = W_RT; isel = I_ZEXT16; end
            6'b001010: begin cls = C_COMP;   op = 3'd1; wsel = W_RT; isel = I_SEXT; end
            6'b100011: begin cls = C_MEM;    op = 3'd0; wsel = W_RT; isel = I_SEXT; end
            6'b101011: begin cls = C_MEM;    op = 3'd1; isel = I_SEXT; end
            6'b000100: begin cls = C_BRANCH; op = 3'd0; isel = I_SEXT; end
            6'b000101: begin cls = C_BRANCH; op = 3'd1; isel = I_SEXT; end
            6'b000111: begin cls = C_BRANCH; op = 3'd2; isel = I_SEXT; end
            6'b011000: begin cls = C_BRANCH; op = 3'd3; isel = I_SEXT; end
            6'b011001: begin cls = C_BRANCH; op = 3'd4; isel = I_SEXT; end
            6'b010101: begin cls = C_BRANCH; op = 3'd5; isel = I_SEXT; end
            6'b000010: begin cls = C_JUMP;   op = 3'd0; isel = I_ZEXT26; end
            6'b000011: begin cls = C_JUMP;   op = 3'd2; wsel = W_R31; isel = I_ZEXT26; end
            default:   cls = C_ILLEGAL;
        endcase
    end

    // Extension built by overlaying low bits so XLEN down to 26 needs no zero-width replication
    always_comb begin
        dec        = '0;
        dec.cls    = cls;
        dec.op     = op;
        dec.rs     = instr[25:21];
        dec.rt     = instr[20:16];
        dec.wr_en  = (wsel != W_NONE);
        dec.shamt  = shamt_en ? instr[10:6] : 5'd0;
        case (wsel)
            W_RD:    dec.wr_reg = instr[15:11];
            W_RT:    dec.wr_reg = instr[20:16];
            W_R31:   dec.wr_reg = 5'd31;
            default: dec.wr_reg = 5'd0;
        endcase
        case (isel)
            I_SEXT:   begin dec.imm = {XLEN{instr[15]}}; dec.imm[15:0] = instr[15:0]; end
            I_ZEXT16: dec.imm[15:0] = instr[15:0];
            I_ZEXT26: dec.imm[25:0] = instr[25:0];
            default:  dec.imm = '0;
        endcase
    end

    logic [1:0] state, state_nx;
    logic       ready_q, valid_q;
    dec_t       e0, e1;
    logic       acc, pop;

    assign acc = in_valid && ready_q && !flush;
    assign pop = valid_q && out_ready;

    always_comb begin
        state_nx = state;
        case (state)
            EMPTY:   if (acc) state_nx = ONE;
            ONE:     if (acc && !pop) state_nx = FULL;
                     else if (!acc && pop) state_nx = EMPTY;
            FULL:    if (pop) state_nx = ONE;
            default: state_nx = EMPTY;
        endcase
        if (flush) state_nx = EMPTY;
    end

    // e0 is always the oldest entry, so the output fields come straight from registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            e0        <= '0;
            e1        <= '0;
            dec_count <= '0;
            ill_count <= '0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx != FULL);
            valid_q <= (state_nx != EMPTY);
            if (!flush) begin
                if (pop && state == FULL)
                    e0 <= e1;
                else if (acc && (state == EMPTY || (state == ONE && pop)))
                    e0 <= dec;
                if (acc && state == ONE && !pop)
                    e1 <= dec;
            end
            if (acc && dec_count != {CNT_W{1'b1}})
                dec_count <= dec_count + 1'b1;
            if (acc && dec.cls == C_ILLEGAL && ill_count != {CNT_W{1'b1}})
                ill_count <= ill_count + 1'b1;
        end
    end

    assign in_ready   = ready_q;
    assign out_valid  = valid_q;
    assign out_class  = e0.cls;
    assign out_op     = e0.op;
    assign out_rs     = e0.rs;
    assign out_rt     = e0.rt;
    assign out_wr_en  = e0.wr_en;
    assign out_wr_reg = e0.wr_reg;
    assign out_shamt  = e0.shamt;
    assign out_imm    = e0.imm;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_wr_en;
    logic [2:0]  out_class, out_op;
    logic [4:0]  out_rs, out_rt, out_wr_reg, out_shamt;
    logic [31:0] out_imm;
    logic [15:0] dec_count, ill_count;

    logic        s_in_ready, s_out_valid, s_wr_en;
    logic [2:0]  s_class, s_op;
    logic [4:0]  s_rs, s_rt, s_wr_reg, s_shamt;
    logic [31:0] s_imm;
    logic [3:0]  s_dec_count, s_ill_count;

    decode_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt), .out_wr_en(out_wr_en),
        .out_wr_reg(out_wr_reg), .out_shamt(out_shamt), .out_imm(out_imm),
        .dec_count(dec_count), .ill_count(ill_count)
    );

    decode_stage #(.XLEN(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .instr(instr), .out_valid(s_out_valid), .out_ready(out_ready), .out_class(s_class),
        .out_op(s_op), .out_rs(s_rs), .out_rt(s_rt), .out_wr_en(s_wr_en),
        .out_wr_reg(s_wr_reg), .out_shamt(s_shamt), .out_imm(s_imm),
        .dec_count(s_dec_count), .ill_count(s_ill_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  cls;
        logic [2:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        wr_en;
        logic [4:0]  wr_reg;
        logic [4:0]  shamt;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[20];
    vec_t sb[$];
    int   passed = 0;
    int   total = 0;
    bit   streaming = 1'b0;
    bit   first_done = 1'b0;
    int   bubbles = 0;

    function automatic vec_t mk(input logic [31:0] i, input logic [2:0] c, input logic [2:0] o,
                                input logic we, input logic [4:0] wr, input logic [4:0] sh,
                                input logic [31:0] im);
        vec_t v;
        v.instr = i; v.cls = c; v.op = o; v.rs = i[25:21]; v.rt = i[20:16];
        v.wr_en = we; v.wr_reg = wr; v.shamt = sh; v.imm = im;
        return v;
    endfunction

    function automatic logic [63:0] pack_exp(input vec_t v);
        return {5'd0, v.cls, v.op, v.rs, v.rt, v.wr_en, v.wr_reg, v.shamt, v.imm};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {29'd0, out_class, out_imm}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk($sformatf("out_fields[%h]", e.instr),
                    {5'd0, out_class, out_op, out_rs, out_rt, out_wr_en, out_wr_reg, out_shamt, out_imm},
                    pack_exp(e));
            end
        end
    end

    task automatic send(input vec_t v);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        instr = v.instr;
        for (int t = 0; t < 10 && !ok; t++) begin
            @(negedge clk);
            if (streaming && first_done && !out_valid) bubbles++;
            if (in_ready) begin
                sb.push_back(v);
                ok = 1'b1;
                first_done = 1'b1;
            end else if (streaming) begin
                bubbles++;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        instr = 32'h20010005;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        sb.delete();
    endtask

    initial begin
        vecs[0]  = mk(32'h20010005, 3'd0, 3'd4, 1'b1, 5'd1,  5'd0,  32'h00000005);
        vecs[1]  = mk(32'h3001FFFF, 3'd1, 3'd2, 1'b1, 5'd1,  5'd0,  32'h0000FFFF);
        vecs[2]  = mk(32'h2001FFFF, 3'd0, 3'd4, 1'b1, 5'd1,  5'd0,  32'hFFFFFFFF);
        vecs[3]  = mk(32'h00221820, 3'd0, 3'd0, 1'b1, 5'd3,  5'd0,  32'h0);
        vecs[4]  = mk(32'h000521C0, 3'd1, 3'd4, 1'b1, 5'd4,  5'd7,  32'h0);
        vecs[5]  = mk(32'h00E8302A, 3'd2, 3'd0, 1'b1, 5'd6,  5'd0,  32'h0);
        vecs[6]  = mk(32'h03E00008, 3'd5, 3'd1, 1'b0, 5'd0,  5'd0,  32'h0);
        vecs[7]  = mk(32'h8D49FFFC, 3'd3, 3'd0, 1'b1, 5'd9,  5'd0,  32'hFFFFFFFC);
        vecs[8]  = mk(32'hAD490008, 3'd3, 3'd1, 1'b0, 5'd0,  5'd0,  32'h00000008);
        vecs[9]  = mk(32'h1022FFFF, 3'd4, 3'd0, 1'b0, 5'd0,  5'd0,  32'hFFFFFFFF);
        vecs[10] = mk(32'h0C123456, 3'd5, 3'd2, 1'b1, 5'd31, 5'd0,  32'h00123456);
        vecs[11] = mk(32'h0BFFFFFF, 3'd5, 3'd0, 1'b0, 5'd0,  5'd0,  32'h03FFFFFF);
        vecs[12] = mk(32'hFC000000, 3'd7, 3'd0, 1'b0, 5'd0,  5'd0,  32'h0);
        vecs[13] = mk(32'h0000003F, 3'd7, 3'd0, 1'b0, 5'd0,  5'd0,  32'h0);
        vecs[14] = mk(32'h34438001, 3'd1, 3'd3, 1'b1, 5'd3,  5'd0,  32'h00008001);
        vecs[15] = mk(32'h28228000, 3'd2, 3'd1, 1'b1, 5'd2,  5'd0,  32'hFFFF8000);
        vecs[16] = mk(32'h24040001, 3'd0, 3'd6, 1'b1, 5'd4,  5'd0,  32'h00000001);
        vecs[17] = mk(32'h1C200010, 3'd4, 3'd2, 1'b0, 5'd0,  5'd0,  32'h00000010);
        vecs[18] = mk(32'h00021FC2, 3'd1, 3'd5, 1'b1, 5'd3,  5'd31, 32'h0);
        vecs[19] = mk(32'h00430822, 3'd0, 3'd1, 1'b1, 5'd1,  5'd0,  32'h0);

        // reset with in_valid held high
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_dec_count", 64'(dec_count), 64'd0);
        chk("rst_ill_count", 64'(ill_count), 64'd0);
        chk("rst_fields", {out_class, out_op, out_wr_en, out_wr_reg, out_imm}, 64'd0);
        @(posedge clk); #1;

        // directed decode table
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(vecs[i]);
        drain();
        @(negedge clk);
        chk("table_dec_count", 64'(dec_count), 64'd20);
        chk("table_ill_count", 64'(ill_count), 64'd2);
        @(posedge clk); #1;

        // backpressure
        do_reset();
        out_ready = 1'b0;
        send(vecs[0]);
        send(vecs[1]);
        instr = vecs[2].instr;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk("bp_hold_head", {29'd0, out_class, out_imm}, {29'd0, vecs[0].cls, vecs[0].imm});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(vecs[2]);
        drain();
        @(negedge clk);
        chk("bp_dec_count", 64'(dec_count), 64'd3);
        @(posedge clk); #1;

        // streaming 100 back-to-back
        do_reset();
        out_ready = 1'b1;
        streaming = 1'b1;
        first_done = 1'b0;
        bubbles = 0;
        for (int i = 0; i < 100; i++) send(vecs[i % 20]);
        streaming = 1'b0;
        drain();
        chk("stream_bubbles", 64'(bubbles), 64'd0);
        @(negedge clk);
        chk("stream_dec_count", 64'(dec_count), 64'd100);
        @(posedge clk); #1;

        // illegal decode and counter saturation
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(vecs[12]);
        drain();
        @(negedge clk);
        chk("sat_ill_count", 64'(s_ill_count), 64'd15);
        chk("sat_dec_count", 64'(s_dec_count), 64'd15);
        chk("wide_ill_count", 64'(ill_count), 64'd20);
        @(posedge clk); #1;

        // flush of a full buffer with in_valid high
        do_reset();
        out_ready = 1'b0;
        send(vecs[3]);
        send(vecs[4]);
        in_valid = 1'b1;
        instr = vecs[5].instr;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_dec_count", 64'(dec_count), 64'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(vecs[7]);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
